// File: rtl/nn_weight_loader_pkg.sv
// nn_weight_loader_pkg: shared MLP sizing defaults and the loader state encoding
// (the AXI-Lite status register decodes the loader state from these values).
package nn_weight_loader_pkg;
    localparam int data_width = 32;
    localparam int num_neuron_layer_1 = 30;
    localparam int num_weight_layer_1 = 784;
    localparam int num_neuron_layer_2 = 30;
    localparam int num_weight_layer_2 = 30;
    localparam int num_neuron_layer_3 = 10;
    localparam int num_weight_layer_3 = 30;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BIAS = 2'd1,
        WGT  = 2'd2
    } nn_loader_state_t;
endpackage

// File: rtl/nn_weight_loader_if.sv
// nn_weight_loader_if: config word stream into the loader and the per-layer
// weight/bias config bus out of it.
interface nn_weight_loader_if #(parameter int DATA_W = 32);
    logic [DATA_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_last;
    logic              cfg_ready;
    logic [31:0]       layer_num;
    logic [31:0]       neuron_num;
    logic [DATA_W-1:0] weight_value;
    logic              weight_valid;
    logic [DATA_W-1:0] bias_value;
    logic              bias_valid;
    modport master (
        output cfg_data, cfg_valid, cfg_last,
        input  cfg_ready, layer_num, neuron_num, weight_value, weight_valid, bias_value, bias_valid
    );
    modport slave (
        input  cfg_data, cfg_valid, cfg_last,
        output cfg_ready, layer_num, neuron_num, weight_value, weight_valid, bias_value, bias_valid
    );
endinterface

// File: rtl/nn_weight_loader.sv
// nn_weight_loader: walks layer -> neuron -> (bias, weights) over one config word
// stream, drives the layer config bus and holds inference while a load runs.
module nn_weight_loader
    import nn_weight_loader_pkg::*;
#(
    parameter int DATA_W = data_width,
    parameter int L1_NN  = num_neuron_layer_1,
    parameter int L1_NW  = num_weight_layer_1,
    parameter int L2_NN  = num_neuron_layer_2,
    parameter int L2_NW  = num_weight_layer_2,
    parameter int L3_NN  = num_neuron_layer_3,
    parameter int L3_NW  = num_weight_layer_3
) (
    input  logic              s_axi_aclk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    nn_weight_loader_if.slave cfg,
    output logic              infer_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int MAX_NN = L1_NN > L2_NN ? (L1_NN > L3_NN ? L1_NN : L3_NN) : (L2_NN > L3_NN ? L2_NN : L3_NN);
    localparam int MAX_NW = L1_NW > L2_NW ? (L1_NW > L3_NW ? L1_NW : L3_NW) : (L2_NW > L3_NW ? L2_NW : L3_NW);
    localparam int NCW = MAX_NN > 1 ? $clog2(MAX_NN) : 1;
    localparam int WCW = MAX_NW > 1 ? $clog2(MAX_NW) : 1;

    nn_loader_state_t state, state_nxt;
    logic [1:0]     layer;
    logic [NCW-1:0] ncnt;
    logic [WCW-1:0] wcnt;
    logic [31:0]    nn, nw;
    logic           accept, go, last_w, last_n, final_w;

    assign cfg.cfg_ready = state != IDLE;
    assign busy          = state != IDLE;
    assign infer_hold    = state != IDLE;

    always_comb begin
        nn        = layer == 2'd1 ? 32'(L1_NN) : layer == 2'd2 ? 32'(L2_NN) : 32'(L3_NN);
        nw        = layer == 2'd1 ? 32'(L1_NW) : layer == 2'd2 ? 32'(L2_NW) : 32'(L3_NW);
        accept    = cfg.cfg_valid && cfg.cfg_ready;
        go        = state == IDLE && start && !abort;
        last_w    = state == WGT && 32'(wcnt) == nw - 32'd1;
        last_n    = 32'(ncnt) == nn - 32'd1;
        final_w   = last_w && last_n && layer == 2'd3;
        // an early cfg_last ends the load just like the true final word
        state_nxt = state == IDLE ? (go ? BIAS : IDLE)
                  : (abort || (accept && (cfg.cfg_last || final_w))) ? IDLE
                  : !accept ? state
                  : (state == BIAS || !last_w) ? WGT : BIAS;
    end

    always_ff @(posedge s_axi_aclk) state <= reset ? IDLE : state_nxt;

    always_ff @(posedge s_axi_aclk) begin
        if (reset) begin
            layer            <= 2'd1;
            ncnt             <= '0;
            wcnt             <= '0;
            cfg.layer_num    <= 32'd1;
            cfg.neuron_num   <= '0;
            cfg.weight_value <= '0;
            cfg.weight_valid <= 1'b0;
            cfg.bias_value   <= '0;
            cfg.bias_valid   <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
        end else begin
            cfg.bias_valid   <= accept && state == BIAS;
            cfg.weight_valid <= accept && state == WGT;
            done             <= accept && final_w && !abort;
            if (go)
                err <= 1'b0;
            else if (accept && (cfg.cfg_last != final_w))
                err <= 1'b1;
            if (accept) begin
                cfg.layer_num  <= 32'(layer);
                cfg.neuron_num <= 32'(ncnt);
                if (state == BIAS)
                    cfg.bias_value <= cfg.cfg_data;
                else
                    cfg.weight_value <= cfg.cfg_data;
            end
            if (go) begin
                layer <= 2'd1;
                ncnt  <= '0;
                wcnt  <= '0;
            end else if (accept && state == WGT) begin
                if (!last_w)
                    wcnt <= wcnt + 1'b1;
                else begin
                    wcnt <= '0;
                    ncnt <= last_n ? '0 : ncnt + 1'b1;
                    if (last_n && layer != 2'd3)
                        layer <= layer + 2'd1;
                end
            end
        end
    end
endmodule
